// File: rtl/pma_region_unit_pkg.sv
// Shared types and constants for the run-time programmable PMA region table.
package pma_region_unit_pkg;

  // Width of the table version counter (counts accepted writes, wraps).
  localparam int unsigned PmaVersionWidth = 8;

  // Number of attribute bits carried per region.
  localparam int unsigned PmaAttrWidth = 3;

  // Bit positions inside the attr/ctrl configuration word.
  localparam int unsigned CtrlCachedBit = 0;
  localparam int unsigned CtrlIdemBit   = 1;
  localparam int unsigned CtrlExecBit   = 2;
  localparam int unsigned CtrlEnBit     = 3;
  localparam int unsigned CtrlLockBit   = 4;

  // Region attributes, packed so that bit0 = cached, bit1 = idempotent, bit2 = exec.
  typedef struct packed {
    logic exec;
    logic idempotent;
    logic cached;
  } pma_attr_t;

  // Field selector for configuration accesses.
  typedef enum logic [1:0] {
    CFG_FIELD_BASE   = 2'd0,
    CFG_FIELD_LENGTH = 2'd1,
    CFG_FIELD_CTRL   = 2'd2,
    CFG_FIELD_RSVD   = 2'd3
  } cfg_field_e;

  // Assemble the 5-bit attr/ctrl word as it is seen by a configuration read.
  function automatic logic [4:0] pack_ctrl(input pma_attr_t attr, input logic en, input logic lock);
    return {lock, en, attr.exec, attr.idempotent, attr.cached};
  endfunction

endpackage

// File: rtl/pma_region_unit_match.sv
// Combinational priority matcher: finds the lowest-index enabled region that
// contains addr_i and returns its attributes. A miss returns all-zero attributes.
module pma_match
  import pma_region_unit_pkg::*;
#(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0]              addr_i,
  input  logic [NrRules*AddrWidth-1:0]      base_i,
  input  logic [NrRules*AddrWidth-1:0]      length_i,
  input  logic [NrRules*PmaAttrWidth-1:0]   attr_i,
  input  logic [NrRules-1:0]                en_i,
  output logic                              hit_o,
  output logic [PmaAttrWidth-1:0]           attr_o
);

  logic [NrRules-1:0] match;

  // Per-region containment test. The offset is computed as an unsigned
  // difference only after addr >= base is known, so an address below the base
  // can never wrap into a false hit, while a region ending exactly at the top
  // of the address space still matches.
  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] len;
    logic [AddrWidth-1:0] offset;

    assign base     = base_i[g*AddrWidth +: AddrWidth];
    assign len      = length_i[g*AddrWidth +: AddrWidth];
    assign offset   = addr_i - base;
    assign match[g] = en_i[g] && (len != '0) && (addr_i >= base) && (offset < len);
  end

  // Lowest matching index wins: scan from the top so the last assignment is the lowest hit.
  always_comb begin
    hit_o  = 1'b0;
    attr_o = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o  = 1'b1;
        attr_o = attr_i[i*PmaAttrWidth +: PmaAttrWidth];
      end
    end
  end

endmodule

// File: rtl/pma_region_unit.sv
// Run-time programmable PMA region table. Holds NrRules regions programmed via
// a request/grant register port and serves NrPorts independent lookups with
// one cycle of registered latency.
//
// Config handshake: cfg_gnt_o mirrors cfg_req_i in the same cycle, so every
// request is accepted when presented; cfg_rvalid_o pulses exactly one cycle
// later with cfg_rdata_o/cfg_err_o. Writes respond with rdata = 0. There is no
// backpressure on either the config or the lookup side.
module pma_region_unit
  import pma_region_unit_pkg::*;
#(
  parameter int unsigned          NrRules     = 8,
  parameter int unsigned          NrPorts     = 2,
  parameter int unsigned          AddrWidth   = 64,
  parameter logic [AddrWidth-1:0] ResetBase   = 64'h8000_0000,
  parameter logic [AddrWidth-1:0] ResetLength = 64'h4000_0000,
  parameter logic [2:0]           ResetAttr   = 3'b111,
  localparam int unsigned         IdxWidth    = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [IdxWidth-1:0]          cfg_idx_i,
  input  logic [1:0]                   cfg_field_i,
  input  logic [AddrWidth-1:0]         cfg_wdata_i,
  output logic                         cfg_gnt_o,
  output logic                         cfg_rvalid_o,
  output logic [AddrWidth-1:0]         cfg_rdata_o,
  output logic                         cfg_err_o,
  input  logic [NrPorts-1:0]           lkp_valid_i,
  input  logic [NrPorts*AddrWidth-1:0] lkp_addr_i,
  output logic [NrPorts-1:0]           lkp_valid_o,
  output logic [NrPorts-1:0]           lkp_hit_o,
  output logic [NrPorts-1:0]           lkp_cached_o,
  output logic [NrPorts-1:0]           lkp_idempotent_o,
  output logic [NrPorts-1:0]           lkp_exec_o,
  output logic [PmaVersionWidth-1:0]   table_version_o
);

  // ---------------------------------------------------------------------------
  // Region table storage
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0]    base_q   [NrRules];
  logic [AddrWidth-1:0]    length_q [NrRules];
  logic [PmaAttrWidth-1:0] attr_q   [NrRules];
  logic [NrRules-1:0]      en_q;
  logic [NrRules-1:0]      lock_q;

  logic [NrRules*AddrWidth-1:0]    base_flat;
  logic [NrRules*AddrWidth-1:0]    length_flat;
  logic [NrRules*PmaAttrWidth-1:0] attr_flat;

  for (genvar g = 0; g < NrRules; g++) begin : g_flat
    assign base_flat[g*AddrWidth +: AddrWidth]          = base_q[g];
    assign length_flat[g*AddrWidth +: AddrWidth]        = length_q[g];
    assign attr_flat[g*PmaAttrWidth +: PmaAttrWidth]    = attr_q[g];
  end

  // ---------------------------------------------------------------------------
  // Config access decode
  // ---------------------------------------------------------------------------
  cfg_field_e              field;
  logic                    idx_valid;
  logic [AddrWidth-1:0]    sel_base;
  logic [AddrWidth-1:0]    sel_length;
  pma_attr_t               sel_attr;
  logic                    sel_en;
  logic                    sel_lock;
  logic [AddrWidth-1:0]    rdata_d;
  logic                    err_d;
  logic                    wr_ok;

  assign field     = cfg_field_e'(cfg_field_i);
  // Only matters when NrRules is not a power of two: upper indices have no entry.
  assign idx_valid = (32'(cfg_idx_i) < NrRules);
  assign cfg_gnt_o = cfg_req_i;

  // Select the addressed entry; an out-of-range index selects nothing (all zero, unlocked).
  always_comb begin
    sel_base   = '0;
    sel_length = '0;
    sel_attr   = '0;
    sel_en     = 1'b0;
    sel_lock   = 1'b0;
    for (int i = 0; i < NrRules; i++) begin
      if (cfg_idx_i == IdxWidth'(i)) begin
        sel_base   = base_q[i];
        sel_length = length_q[i];
        sel_attr   = pma_attr_t'(attr_q[i]);
        sel_en     = en_q[i];
        sel_lock   = lock_q[i];
      end
    end
  end

  // Read data for the addressed field, sampled in the grant cycle.
  always_comb begin
    rdata_d = '0;
    unique case (field)
      CFG_FIELD_BASE:   rdata_d = sel_base;
      CFG_FIELD_LENGTH: rdata_d = sel_length;
      CFG_FIELD_CTRL:   rdata_d = AddrWidth'(pack_ctrl(sel_attr, sel_en, sel_lock));
      default:          rdata_d = '0;
    endcase
    if (!idx_valid) begin
      rdata_d = '0;
    end
  end

  // Error on reserved field or missing entry; writes also fail on a locked entry.
  // A locked entry rejects every write, which is also what keeps lock sticky.
  always_comb begin
    err_d = 1'b0;
    if (cfg_req_i) begin
      err_d = !idx_valid || (field == CFG_FIELD_RSVD) || (cfg_we_i && sel_lock);
    end
    wr_ok = cfg_req_i && cfg_we_i && !err_d;
  end

  // Table update at the end of the grant cycle; lookups in that cycle still see the old table.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i]   <= (i == 0) ? ResetBase   : '0;
        length_q[i] <= (i == 0) ? ResetLength : '0;
        attr_q[i]   <= (i == 0) ? ResetAttr   : '0;
      end
      en_q   <= NrRules'(1);
      lock_q <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NrRules; i++) begin
        if (cfg_idx_i == IdxWidth'(i)) begin
          unique case (field)
            CFG_FIELD_BASE:   base_q[i]   <= cfg_wdata_i;
            CFG_FIELD_LENGTH: length_q[i] <= cfg_wdata_i;
            CFG_FIELD_CTRL: begin
              attr_q[i] <= {cfg_wdata_i[CtrlExecBit], cfg_wdata_i[CtrlIdemBit],
                            cfg_wdata_i[CtrlCachedBit]};
              en_q[i]   <= cfg_wdata_i[CtrlEnBit];
              lock_q[i] <= cfg_wdata_i[CtrlLockBit];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Config response register: one-cycle pulse, zero data/err when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= err_d;
      cfg_rdata_o  <= (cfg_req_i && !cfg_we_i) ? rdata_d : '0;
    end
  end

  // Version counter: counts accepted writes, wrapping naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      table_version_o <= '0;
    end else if (wr_ok) begin
      table_version_o <= table_version_o + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup ports
  // ---------------------------------------------------------------------------
  logic [NrPorts-1:0]              hit_d;
  logic [NrPorts*PmaAttrWidth-1:0] attr_d;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    pma_match #(
      .NrRules   (NrRules),
      .AddrWidth (AddrWidth)
    ) u_match (
      .addr_i   (lkp_addr_i[p*AddrWidth +: AddrWidth]),
      .base_i   (base_flat),
      .length_i (length_flat),
      .attr_i   (attr_flat),
      .en_i     (en_q),
      .hit_o    (hit_d[p]),
      .attr_o   (attr_d[p*PmaAttrWidth +: PmaAttrWidth])
    );
  end

  // Register lookup results; attributes only load on a valid request and hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_valid_o      <= '0;
      lkp_hit_o        <= '0;
      lkp_cached_o     <= '0;
      lkp_idempotent_o <= '0;
      lkp_exec_o       <= '0;
    end else begin
      lkp_valid_o <= lkp_valid_i;
      for (int p = 0; p < NrPorts; p++) begin
        if (lkp_valid_i[p]) begin
          lkp_hit_o[p]        <= hit_d[p];
          lkp_cached_o[p]     <= attr_d[p*PmaAttrWidth + 0];
          lkp_idempotent_o[p] <= attr_d[p*PmaAttrWidth + 1];
          lkp_exec_o[p]       <= attr_d[p*PmaAttrWidth + 2];
        end
      end
    end
  end

endmodule

// File: doc/pma_region_unit.md
Name: pma_region_unit

Overview:
- Run-time programmable physical-memory-attribute (PMA) region table.
- Replaces the static cached, non-idempotent and execute region rules currently fixed at elaboration in the core configuration package.
- Serves NrPorts independent address lookups (fetch, load/store, PTW) with one-cycle registered latency.
- Programmed by the CSR/debug path through a request/grant register interface with per-entry lock bits.

Parameters:
- NrRules, 8, number of region entries (1..16).
- NrPorts, 2, number of independent lookup channels.
- AddrWidth, 64, physical address width.
- ResetBase, 64'h8000_0000, entry 0 base at reset.
- ResetLength, 64'h4000_0000, entry 0 length at reset.
- ResetAttr, 3'b111, entry 0 attributes at reset, as {exec, idempotent, cached}.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_req_i  in  1  config access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_idx_i  in  $clog2(NrRules)  entry index
- cfg_field_i  in  2  0 = base, 1 = length, 2 = attr/ctrl, 3 = reserved
- cfg_wdata_i  in  AddrWidth  write data
- cfg_gnt_o  out  1  request accepted
- cfg_rvalid_o  out  1  response valid
- cfg_rdata_o  out  AddrWidth  read data
- cfg_err_o  out  1  error flag, qualified by cfg_rvalid_o
- lkp_valid_i  in  NrPorts  lookup request per port
- lkp_addr_i  in  NrPorts*AddrWidth  lookup addresses
- lkp_valid_o  out  NrPorts  result valid
- lkp_hit_o  out  NrPorts  some enabled entry matched
- lkp_cached_o  out  NrPorts  result attribute
- lkp_idempotent_o  out  NrPorts  result attribute
- lkp_exec_o  out  NrPorts  result attribute
- table_version_o  out  8  counter of accepted writes

Behaviour:
- Entry fields: base, length, attr {exec, idempotent, cached}, en, lock.
- Attr/ctrl word layout: bit0 cached, bit1 idempotent, bit2 exec, bit3 en, bit4 lock; upper bits read 0.
- Reset values:
  - Entry 0: ResetBase, ResetLength, ResetAttr, en=1, lock=0.
  - All other entries: zero, en=0, lock=0.
  - All outputs 0; table_version_o = 0.
- Match rule: en && length != 0 && addr >= base && (addr - base) < length.
  - Subtraction is unsigned AddrWidth, so no wrap-around false hit.
  - Region spanning the top of the address space is legal.
- Priority: lowest matching index wins.
- Miss result: hit=0, cached=0, idempotent=0, exec=0 (conservative).
- Lookup timing:
  - Combinational match on cycle N; results registered; lkp_valid_o and attributes valid on N+1.
  - No backpressure.
  - Ports are independent; all NrPorts may look up every cycle.
  - lkp_valid_o low ⇒ attribute outputs hold their previous values (don't care).
- Config handshake:
  - cfg_gnt_o = cfg_req_i combinationally; every request is granted in the cycle presented.
  - Response cfg_rvalid_o pulses exactly one cycle later.
- Write rules:
  - Accepted write updates the entry at the clock edge ending the grant cycle.
  - A lookup in that same cycle uses the old table; the new value is visible from the next cycle.
  - Write to a locked entry: no update, cfg_err_o=1, version unchanged.
  - Write to field 3: no update, cfg_err_o=1, version unchanged.
  - Write clearing lock is ignored while lock=1; lock is only cleared by reset.
  - Setting lock in the same write as other ctrl bits applies all bits.
  - Successful write: table_version_o increments, 255 wraps to 0.
- Read rules:
  - cfg_rdata_o returns the field value sampled in the grant cycle.
  - Field 3 returns 0 with cfg_err_o=1.
  - Out-of-range cfg_idx_i (NrRules not a power of 2): read 0 with err=1; write ignored with err=1.
- Reset mid-operation: table returns to reset contents immediately; pending responses and lookup results are dropped (valids 0).

Decomposition:
- Add to config_pkg:
  - pma_attr_t struct {exec, idempotent, cached}.
  - pma_entry_t struct {base, length, attr, en, lock}.
  - cfg_field_e enum.
  - PmaVersionWidth = 8.
- cva6_cfg_t gains NrPmaRules; static rule fields supply ResetBase/ResetLength.
- Sub-module pma_match: combinational per-port priority matcher over the table, instantiated NrPorts times.

Test Plan:
- Reset, lookup 0x8000_1000 on port 0 → next cycle hit=1, cached=1, idem=1, exec=1. Lookup 0x1000_0000 → hit=0, all attributes 0.
- Write entry 1: base 0x1_0000, len 0x1_0000, attr 0b01110 (idem, exec, en); lookup 0x1_FFFF → hit, exec=1, cached=0. Lookup 0x2_0000 → miss. table_version_o = 3.
- Overlap: entry 0 and entry 2 both cover 0x8000_0000, entry 2 non-cached → entry 0 attributes win. Disable entry 0 → entry 2 attributes.
- Lock: write ctrl of entry 1 with lock=1, then write base → cfg_err_o=1, base unchanged, version not incremented.
- Same-cycle write of entry 0 en=0 and lookup 0x8000_0000 → hit=1; lookup next cycle → hit=0.
- Top-of-space region base 0xFFFF_FFFF_FFFF_F000, len 0x1000: lookup 0xFFFF_FFFF_FFFF_FFFF → hit; lookup 0x0 → miss. Version counter wraps 255 → 0 after 256 writes.
